// File: rtl/hidden_cpu_sequencer_pkg.sv
// Shared definitions for the hidden CPU sequencer: FSM encoding,
// instruction byte field positions and the default idle instruction.
package hidden_cpu_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned OPC_MSB   = 7;
  localparam int unsigned OPC_LSB   = 6;
  localparam int unsigned REG0_MSB  = 5;
  localparam int unsigned REG0_LSB  = 4;
  localparam int unsigned REG1_MSB  = 3;
  localparam int unsigned REG1_LSB  = 2;
  localparam int unsigned SPARE_MSB = 1;
  localparam int unsigned SPARE_LSB = 0;

  localparam logic [7:0] DEF_NOP = 8'h00;

endpackage

// File: rtl/hidden_cpu_sequencer_if.sv
// Host load/control and CPU-core signals of the sequencer, bundled as one port.
interface hidden_cpu_sequencer_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             load_valid;
  logic [7:0]       load_data;
  logic             load_ready;
  logic             clear;
  logic             start;
  logic             halt;
  logic             step_mode;
  logic             step;
  logic [7:0]       core_pc;
  logic [7:0]       instr;
  logic             instr_valid;
  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             err;

  modport master (
    output load_valid, load_data, clear, start, halt, step_mode, step, core_pc,
    input  load_ready, instr, instr_valid, state, count, err
  );

  modport slave (
    input  load_valid, load_data, clear, start, halt, step_mode, step, core_pc,
    output load_ready, instr, instr_valid, state, count, err
  );

endinterface

// File: rtl/hidden_cpu_sequencer_prog_buffer.sv
// Program storage: DEPTH x 8, one write port and one registered read port.
// Contents are intentionally not reset.
module prog_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/hidden_cpu_sequencer.sv
// Loads a small program from the host, then feeds it byte-by-byte to a CPU
// core addressed by the core's own program counter.
module hidden_cpu_sequencer
  import hidden_cpu_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter logic [7:0]  NOP   = DEF_NOP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hidden_cpu_sequencer_if.slave  bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_err, w_err_nxt;
  logic             r_issue, w_issue;
  logic             w_wr_en;
  logic             w_pc_end;
  logic [7:0]       w_rd_data;

  // Full 8-bit compare so out-of-range PCs end the program instead of aliasing.
  assign w_pc_end = {1'b0, bus.core_pc} >= 9'(r_count);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    w_wr_en     = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.load_valid) begin
          if (r_count != FULL) begin
            w_wr_en     = 1'b1;
            w_count_nxt = r_count + CNT_W'(1);
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        if (!bus.halt) begin
          if (bus.clear) begin
            w_wr_en     = 1'b0;
            w_count_nxt = '0;
            w_err_nxt   = 1'b0;
          end else if (bus.start) begin
            if (w_count_nxt != '0) w_state_nxt = RUN;
            else                   w_err_nxt   = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.halt)       w_state_nxt = IDLE;
        else if (w_pc_end)  w_state_nxt = DONE;
        else                w_issue     = !bus.step_mode || bus.step;
      end
      DONE: begin
        if (bus.halt) begin
          w_state_nxt = IDLE;
        end else if (bus.clear) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
          w_err_nxt   = 1'b0;
        end else if (bus.start) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_err   <= 1'b0;
      r_issue <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
      r_issue <= w_issue;
    end
  end

  prog_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prog_buffer (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_count[ADDR_W-1:0]),
    .i_wr_data (bus.load_data),
    .i_rd_en   (w_issue),
    .i_rd_addr (bus.core_pc[ADDR_W-1:0]),
    .o_rd_data (w_rd_data)
  );

  // The read register itself is unreset; the reset issue flag gates it to NOP.
  assign bus.instr       = r_issue ? w_rd_data : NOP;
  assign bus.instr_valid = r_issue;
  assign bus.state       = r_state;
  assign bus.count       = r_count;
  assign bus.err         = r_err;
  assign bus.load_ready  = (r_state == IDLE) && (r_count != FULL);

endmodule

// File: tb/tb_hidden_cpu_sequencer.sv
// Directed self-checking bench for hidden_cpu_sequencer (DEPTH=16).
module tb_hidden_cpu_sequencer;

  logic clk;
  logic rst_n;
  int unsigned n_chk;
  int unsigned n_fail;

  hidden_cpu_sequencer_if #(.DEPTH(16)) bus ();

  hidden_cpu_sequencer #(
    .DEPTH (16),
    .NOP   (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.clear      = 1'b0;
    bus.start      = 1'b0;
    bus.halt       = 1'b0;
    bus.step_mode  = 1'b0;
    bus.step       = 1'b0;
    bus.core_pc    = 8'h00;
  endtask

  task automatic load_byte(input logic [7:0] b);
    bus.load_valid = 1'b1;
    bus.load_data  = b;
    tick();
    bus.load_valid = 1'b0;
  endtask

  logic [7:0] prog [3];
  initial begin
    n_chk  = 0;
    n_fail = 0;
    prog[0] = 8'h54;
    prog[1] = 8'h98;
    prog[2] = 8'hD0;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_valid", 32'(bus.instr_valid), 0);
    chk("rst_instr", 32'(bus.instr), 32'h00);
    chk("rst_err", 32'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) load_byte(prog[i]);
    chk("load_count", 32'(bus.count), 3);
    chk("load_ready", 32'(bus.load_ready), 1);
    chk("load_err", 32'(bus.err), 0);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_run", 32'(bus.state), 1);
    chk("start_noissue", 32'(bus.instr_valid), 0);
    for (int i = 0; i < 3; i++) begin
      bus.core_pc = 8'(i);
      tick();
      chk("run_valid", 32'(bus.instr_valid), 1);
      chk("run_instr", 32'(bus.instr), 32'(prog[i]));
    end
    bus.core_pc = 8'd3;
    tick();
    chk("end_state", 32'(bus.state), 2);
    chk("end_valid", 32'(bus.instr_valid), 0);
    chk("end_instr", 32'(bus.instr), 32'h00);

    // Restart from DONE in step mode with pc held at 1.
    bus.step_mode = 1'b1;
    bus.core_pc   = 8'd1;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart_run", 32'(bus.state), 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("step_low_valid", 32'(bus.instr_valid), 0);
    end
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    chk("step_valid", 32'(bus.instr_valid), 1);
    chk("step_instr", 32'(bus.instr), 32'h98);
    tick();
    chk("step_once", 32'(bus.instr_valid), 0);
    bus.step = 1'b1;
    tick();
    chk("step_hold1", 32'(bus.instr_valid), 1);
    tick();
    chk("step_hold2", 32'(bus.instr_valid), 1);
    bus.step = 1'b1;
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    bus.step = 1'b0;
    bus.step_mode = 1'b0;
    chk("halt_state", 32'(bus.state), 0);
    chk("halt_valid", 32'(bus.instr_valid), 0);
    chk("halt_count", 32'(bus.count), 3);

    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr_count", 32'(bus.count), 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("empty_state", 32'(bus.state), 0);
    chk("empty_err", 32'(bus.err), 1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr_err", 32'(bus.err), 0);

    for (int i = 0; i < 16; i++) load_byte(8'(8'h10 + i));
    chk("full_count", 32'(bus.count), 16);
    chk("full_ready", 32'(bus.load_ready), 0);
    chk("full_err0", 32'(bus.err), 0);
    load_byte(8'hEE);
    chk("over_count", 32'(bus.count), 16);
    chk("over_err", 32'(bus.err), 1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr2_count", 32'(bus.count), 0);
    chk("clr2_err", 32'(bus.err), 0);

    // Write and start in the same cycle from an empty buffer.
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hA5;
    bus.start      = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.start      = 1'b0;
    chk("ws_state", 32'(bus.state), 1);
    chk("ws_count", 32'(bus.count), 1);
    chk("ws_err", 32'(bus.err), 0);
    bus.core_pc = 8'h10;
    tick();
    chk("wrap_state", 32'(bus.state), 2);
    chk("wrap_valid", 32'(bus.instr_valid), 0);
    bus.core_pc = 8'h00;
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("ws_valid", 32'(bus.instr_valid), 1);
    chk("ws_instr", 32'(bus.instr), 32'hA5);

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.instr_valid), 0);
    chk("arst_state", 32'(bus.state), 0);
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_instr", 32'(bus.instr), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
